class_switch_wrr: RTL and testbench
===================================

# class_switch_wrr

Parametrised N-class switching stage with a weighted round-robin output. Each incoming word is steered by its class field into one of NUM_CLASS per-class FIFOs. A weighted round-robin arbiter merges the FIFOs onto a single valid/ready output port. Per-class status flags (almost full, almost empty, empty, error, pause) feed upstream flow control. The block replaces the fixed two-class switch and adds configurable class count, programmable service weights, and an output handshake.

## Interface
- DATA_SIZE, 10, word width; class field is in[DATA_SIZE-1 -: CLASS_BITS]
- FIFO_DEPTH, 8, entries per class FIFO, power of two, ≥ 2
- NUM_CLASS, 4, number of classes/FIFOs
- CLASS_BITS, 2, log2(NUM_CLASS)
- WEIGHT_W, 3, width of each class weight
- AF_THRESH, 6, almost-full threshold (occupancy ≥ AF_THRESH)
- AE_THRESH, 2, almost-empty threshold (occupancy ≤ AE_THRESH)
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- in  input  DATA_SIZE  input word
- valid_in  input  1  in is valid this cycle
- weights  input  NUM_CLASS*WEIGHT_W  weight of class i is weights[i*WEIGHT_W +: WEIGHT_W]; sampled live
- out_ready  input  1  downstream accepts out this cycle
- out  output  DATA_SIZE  registered output word
- valid_out  output  1  out holds a valid word
- out_class  output  CLASS_BITS  class of the word in out
- almost_full  output  NUM_CLASS  per-class almost-full flag
- almost_empty  output  NUM_CLASS  per-class almost-empty flag
- fifo_empty  output  NUM_CLASS  per-class empty flag
- fifo_error  output  NUM_CLASS  sticky per-class overflow flag
- fifo_pause  output  NUM_CLASS  per-class pause request; equals almost_full

## Operation
- Ingress:
  - When valid_in=1, the word is pushed into FIFO[class].
  - If that FIFO is full, judged by occupancy at the start of the cycle, the word is dropped and fifo_error[class] is set.
  - A pop of the same FIFO in the same cycle does not rescue a word pushed when full.
  - fifo_error bits clear only on reset.
- FIFO storage: circular buffer with log2(FIFO_DEPTH)-bit read/write pointers that wrap modulo FIFO_DEPTH, plus an occupancy counter of width log2(FIFO_DEPTH)+1.
- Simultaneous push and pop on a non-full FIFO leaves occupancy unchanged.
- There is no bypass: a word pushed into an empty FIFO becomes visible to the arbiter in the following cycle.
- Flags are combinational from occupancy:
  - empty = (count == 0)
  - almost_empty = (count ≤ AE_THRESH)
  - almost_full = (count ≥ AF_THRESH)
  - fifo_pause = almost_full
- Eligibility: class i is eligible when FIFO[i] is non-empty and weight[i] ≠ 0. A class with weight 0 is never served; its data stays in its FIFO.
- Output stage: a one-entry register. A load occurs when (valid_out=0 or out_ready=1) and at least one class is eligible. A load pops the granted FIFO, captures its head into out, writes the class into out_class, and sets valid_out=1.
- If valid_out=1 and out_ready=1 with no eligible class, valid_out goes to 0 and out holds its value.
- Arbiter state: ptr (CLASS_BITS bits) and credit (WEIGHT_W bits). At each load:
  - If class ptr is eligible and credit < weight[ptr], grant ptr and set credit to credit+1.
  - Otherwise, search cyclically from ptr+1 for the first eligible class j, grant j, and set ptr=j, credit=1.
  - If weights change mid-burst, the same rule applies: credit ≥ new weight forces a move.
- Reset values:
  - out=0, valid_out=0, out_class=0
  - all FIFO pointers and counts = 0
  - fifo_empty=all 1, almost_empty=all 1
  - almost_full=0, fifo_pause=0, fifo_error=0
  - ptr=0, credit=0
- Reset takes effect immediately (asynchronously) at any time. Mid-operation it discards all stored and in-flight data.

## Timing
- Latency: a word sampled with valid_in at edge E0 into an empty FIFO, with the output stage free, appears with valid_out=1 after edge E1. That is 2 cycles from valid_in to valid_out.
- Throughput: one word per cycle when out_ready=1 and an eligible class exists.
- While out_ready=0 and valid_out=1, out, out_class and valid_out are held stable.
- Flags reflect occupancy after the most recent edge.

## Test plan
- Fairness (NUM_CLASS=4, weights w0=2, w1=1, w2=1, w3=1):
  - Hold out_ready=0 and push 0x001, 0x002, 0x003, 0x101, 0x102, 0x103 in that order.
  - Then set out_ready=1.
  - Output order must be 0x001, 0x002, 0x101, 0x003, 0x102, 0x103, with out_class 0,0,1,0,1,1.
- Overflow:
  - With out_ready=0, push 0x200..0x209.
  - 0x200 sits in out; 0x201..0x208 fill FIFO 2; 0x209 is dropped.
  - fifo_error[2]=1 and almost_full[2]=fifo_pause[2]=1.
  - On draining, the output is 0x200..0x208, then valid_out=0, and fifo_error[2] stays 1.
- Weight zero:
  - Set w3=0 and push 0x301.
  - valid_out must never rise and fifo_empty[3] stays 0.
  - Then set w3=1: 0x301 must appear within 2 cycles.
- Backpressure/wrap:
  - Stream 20 words to class 1 while toggling out_ready every cycle.
  - Every word must appear exactly once, in order, with out stable whenever out_ready=0 (this covers pointer wrap-around).
- Reset mid-operation:
  - With 5 words queued and valid_out=1, pull reset low between clock edges.
  - All outputs must take their reset values immediately.
  - After release, no stale word may appear.

Source files
------------

// File: rtl/class_switch_wrr_if.sv
// class_switch_wrr_if
//   Bundles the ingress word, the weight vector, the egress valid/ready
//   port and the per-class status flags of class_switch_wrr.
//   slave  : the switch itself (drives out/valid_out/out_class and flags)
//   master : the surrounding logic (drives in/valid_in/weights/out_ready)
interface class_switch_wrr_if #(
    parameter int DATA_SIZE  = 10,
    parameter int NUM_CLASS  = 4,
    parameter int CLASS_BITS = 2,
    parameter int WEIGHT_W   = 3
);
    logic [DATA_SIZE-1:0]          in;
    logic                          valid_in;
    logic [NUM_CLASS*WEIGHT_W-1:0] weights;
    logic                          out_ready;
    logic [DATA_SIZE-1:0]          out;
    logic                          valid_out;
    logic [CLASS_BITS-1:0]         out_class;
    logic [NUM_CLASS-1:0]          almost_full;
    logic [NUM_CLASS-1:0]          almost_empty;
    logic [NUM_CLASS-1:0]          fifo_empty;
    logic [NUM_CLASS-1:0]          fifo_error;
    logic [NUM_CLASS-1:0]          fifo_pause;

    modport master (
        output in, valid_in, weights, out_ready,
        input  out, valid_out, out_class,
        input  almost_full, almost_empty, fifo_empty, fifo_error, fifo_pause
    );

    modport slave (
        input  in, valid_in, weights, out_ready,
        output out, valid_out, out_class,
        output almost_full, almost_empty, fifo_empty, fifo_error, fifo_pause
    );
endinterface

// File: rtl/class_switch_wrr.sv
// class_switch_wrr
//   N-class switching stage. Ingress words are steered by their top
//   CLASS_BITS into per-class circular FIFOs; a weighted round-robin
//   arbiter drains the FIFOs into a one-entry valid/ready output register.
//   Ports:
//     clk    : rising-edge clock
//     reset  : asynchronous active-low reset, clears all state and data
//     bus    : class_switch_wrr_if.slave (ingress, weights, egress, flags)

// class_fifo
//   One per-class circular buffer with occupancy counter.
//   push is dropped (and error latched) when full at the start of the cycle;
//   a concurrent pop does not make room for it. head is the oldest entry.
module class_fifo #(
    parameter int DATA_SIZE  = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_SIZE-1:0]          din,
    output logic [DATA_SIZE-1:0]          head,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          error
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic                 full, push_ok, pop_ok;

    assign full    = (count == CNT_FULL);
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            error  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && full) error <= 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end
endmodule

module class_switch_wrr #(
    parameter int DATA_SIZE  = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_CLASS  = 4,
    parameter int CLASS_BITS = 2,
    parameter int WEIGHT_W   = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic               clk,
    input  logic               reset,
    class_switch_wrr_if.slave  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WEIGHT_W-1:0] W_ONE = WEIGHT_W'(1);

    typedef struct packed {
        logic                  hit;
        logic [CLASS_BITS-1:0] cls;
        logic [WEIGHT_W-1:0]   credit;
    } grant_t;

    logic [NUM_CLASS-1:0][DATA_SIZE-1:0] head;
    logic [NUM_CLASS-1:0][CNT_W-1:0]     count;
    logic [NUM_CLASS-1:0][WEIGHT_W-1:0]  weight;
    logic [NUM_CLASS-1:0] push, pop, elig, empty, ae, af, error;

    logic [CLASS_BITS-1:0] in_class, ptr, idx;
    logic [WEIGHT_W-1:0]   credit;
    logic [DATA_SIZE-1:0]  out_q;
    logic                  valid_q;
    logic [CLASS_BITS-1:0] class_q;
    grant_t                gnt;
    logic                  load;

    assign weight   = bus.weights;
    assign in_class = bus.in[DATA_SIZE-1 -: CLASS_BITS];

    generate
        for (genvar i = 0; i < NUM_CLASS; i++) begin : g_class
            assign push[i] = bus.valid_in && (in_class == CLASS_BITS'(i));
            assign pop[i]  = load && (gnt.cls == CLASS_BITS'(i));

            class_fifo #(
                .DATA_SIZE (DATA_SIZE),
                .FIFO_DEPTH(FIFO_DEPTH)
            ) u_fifo (
                .clk  (clk),
                .reset(reset),
                .push (push[i]),
                .pop  (pop[i]),
                .din  (bus.in),
                .head (head[i]),
                .count(count[i]),
                .error(error[i])
            );

            assign empty[i] = (count[i] == '0);
            assign ae[i]    = (count[i] <= CNT_W'(AE_THRESH));
            assign af[i]    = (count[i] >= CNT_W'(AF_THRESH));
            // Weight 0 parks a class: its data waits until the weight rises.
            assign elig[i]  = !empty[i] && (weight[i] != '0);
        end
    endgenerate

    // Stay on ptr while it has credit left; otherwise take the first eligible
    // class after ptr. The scan runs backwards so the nearest hit wins, and
    // k == NUM_CLASS lands back on ptr so a lone eligible class keeps flowing.
    always_comb begin
        gnt = '0;
        idx = '0;
        if (elig[ptr] && (credit < weight[ptr])) begin
            gnt.hit    = 1'b1;
            gnt.cls    = ptr;
            gnt.credit = credit + W_ONE;
        end else begin
            for (int k = NUM_CLASS; k >= 1; k--) begin
                idx = CLASS_BITS'((int'(ptr) + k) % NUM_CLASS);
                if (elig[idx]) begin
                    gnt.hit    = 1'b1;
                    gnt.cls    = idx;
                    gnt.credit = W_ONE;
                end
            end
        end
    end

    assign load = (!valid_q || bus.out_ready) && gnt.hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            class_q <= '0;
            ptr     <= '0;
            credit  <= '0;
        end else if (load) begin
            out_q   <= head[gnt.cls];
            class_q <= gnt.cls;
            valid_q <= 1'b1;
            ptr     <= gnt.cls;
            credit  <= gnt.credit;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out          = out_q;
    assign bus.valid_out    = valid_q;
    assign bus.out_class    = class_q;
    assign bus.fifo_empty   = empty;
    assign bus.almost_empty = ae;
    assign bus.almost_full  = af;
    assign bus.fifo_pause   = af;
    assign bus.fifo_error   = error;
endmodule

// File: tb/tb_class_switch_wrr.sv
// tb_class_switch_wrr
//   Directed bench for class_switch_wrr: a cycle table for WRR fairness plus
//   hand sequences for overflow, weight zero, backpressure/wrap and
//   asynchronous reset mid-operation.
module tb_class_switch_wrr;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    class_switch_wrr_if #(
        .DATA_SIZE(10), .NUM_CLASS(4), .CLASS_BITS(2), .WEIGHT_W(3)
    ) bus ();

    class_switch_wrr #(
        .DATA_SIZE(10), .FIFO_DEPTH(8), .NUM_CLASS(4), .CLASS_BITS(2),
        .WEIGHT_W(3), .AF_THRESH(6), .AE_THRESH(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       vin;
        logic [9:0] din;
        logic       rdy;
        logic       exp_vo;
        logic [9:0] exp_out;
        logic [1:0] exp_cls;
        logic [3:0] exp_empty;
        logic [3:0] exp_ae;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid_out"},    32'(bus.valid_out),    32'h0);
        chk({tag, "_out"},          32'(bus.out),          32'h0);
        chk({tag, "_out_class"},    32'(bus.out_class),    32'h0);
        chk({tag, "_fifo_empty"},   32'(bus.fifo_empty),   32'hF);
        chk({tag, "_almost_empty"}, 32'(bus.almost_empty), 32'hF);
        chk({tag, "_almost_full"},  32'(bus.almost_full),  32'h0);
        chk({tag, "_fifo_error"},   32'(bus.fifo_error),   32'h0);
        chk({tag, "_fifo_pause"},   32'(bus.fifo_pause),   32'h0);
    endtask

    task automatic do_reset(input string tag);
        bus.valid_in  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk_reset_vals(tag);
        step();
        step();
        #3 reset = 1'b1;
        step();
    endtask

    initial begin
        logic       pv, pr;
        logic [9:0] po;
        logic [1:0] pc;
        int sent, rcvd, n;

        bus.valid_in  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b0;
        bus.weights   = 12'h24A;   // w3=1 w2=1 w1=1 w0=2
        reset         = 1'b0;

        //             vin  din     rdy  vo    out     cls   empty    ae
        tbl[0]  = '{1'b1, 10'h001, 1'b0, 1'b0, 10'h000, 2'd0, 4'b1110, 4'b1111};
        tbl[1]  = '{1'b1, 10'h002, 1'b0, 1'b1, 10'h001, 2'd0, 4'b1110, 4'b1111};
        tbl[2]  = '{1'b1, 10'h003, 1'b0, 1'b1, 10'h001, 2'd0, 4'b1110, 4'b1111};
        tbl[3]  = '{1'b1, 10'h101, 1'b0, 1'b1, 10'h001, 2'd0, 4'b1100, 4'b1111};
        tbl[4]  = '{1'b1, 10'h102, 1'b0, 1'b1, 10'h001, 2'd0, 4'b1100, 4'b1111};
        tbl[5]  = '{1'b1, 10'h103, 1'b0, 1'b1, 10'h001, 2'd0, 4'b1100, 4'b1101};
        tbl[6]  = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h002, 2'd0, 4'b1100, 4'b1101};
        tbl[7]  = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h101, 2'd1, 4'b1100, 4'b1111};
        tbl[8]  = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h003, 2'd0, 4'b1101, 4'b1111};
        tbl[9]  = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h102, 2'd1, 4'b1101, 4'b1111};
        tbl[10] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h103, 2'd1, 4'b1111, 4'b1111};
        tbl[11] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h103, 2'd1, 4'b1111, 4'b1111};

        // ---------------- fairness table ----------------
        do_reset("rst_init");
        bus.weights = 12'h24A;
        for (int i = 0; i < 12; i++) begin
            bus.valid_in  = tbl[i].vin;
            bus.in        = tbl[i].din;
            bus.out_ready = tbl[i].rdy;
            step();
            chk($sformatf("fair%0d_vo", i),    32'(bus.valid_out),    32'(tbl[i].exp_vo));
            chk($sformatf("fair%0d_out", i),   32'(bus.out),          32'(tbl[i].exp_out));
            chk($sformatf("fair%0d_cls", i),   32'(bus.out_class),    32'(tbl[i].exp_cls));
            chk($sformatf("fair%0d_empty", i), 32'(bus.fifo_empty),   32'(tbl[i].exp_empty));
            chk($sformatf("fair%0d_ae", i),    32'(bus.almost_empty), 32'(tbl[i].exp_ae));
        end

        // ---------------- overflow ----------------
        do_reset("rst_ovf");
        bus.weights = 12'h249;
        for (int k = 0; k < 10; k++) begin
            bus.valid_in = 1'b1;
            bus.in = 10'h200 + 10'(k);
            step();
            if (k == 5) chk("ovf_af_at5", 32'(bus.almost_full[2]), 32'h0);
            if (k == 6) chk("ovf_af_at6", 32'(bus.almost_full[2]), 32'h1);
            if (k == 8) chk("ovf_err_full", 32'(bus.fifo_error[2]), 32'h0);
        end
        bus.valid_in = 1'b0;
        chk("ovf_err",   32'(bus.fifo_error),  32'h4);
        chk("ovf_af",    32'(bus.almost_full), 32'h4);
        chk("ovf_pause", 32'(bus.fifo_pause),  32'h4);
        chk("ovf_empty2", 32'(bus.fifo_empty[2]), 32'h0);
        chk("ovf_vo",    32'(bus.valid_out), 32'h1);
        chk("ovf_out",   32'(bus.out), 32'h200);
        chk("ovf_cls",   32'(bus.out_class), 32'h2);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("ovf_drain%0d_vo", k),  32'(bus.valid_out), 32'h1);
            chk($sformatf("ovf_drain%0d_out", k), 32'(bus.out), 32'h201 + 32'(k));
        end
        step();
        chk("ovf_end_vo",  32'(bus.valid_out), 32'h0);
        chk("ovf_end_err", 32'(bus.fifo_error[2]), 32'h1);
        chk("ovf_end_empty", 32'(bus.fifo_empty), 32'hF);

        // ---------------- weight zero ----------------
        do_reset("rst_wz");
        bus.weights   = 12'h049;   // w3=0
        bus.out_ready = 1'b1;
        bus.valid_in  = 1'b1;
        bus.in        = 10'h301;
        step();
        bus.valid_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("wz_hold%0d_vo", k),    32'(bus.valid_out), 32'h0);
            chk($sformatf("wz_hold%0d_empty", k), 32'(bus.fifo_empty[3]), 32'h0);
            step();
        end
        bus.weights = 12'h249;
        n = 0;
        while (!bus.valid_out && n < 2) begin
            step();
            n++;
        end
        chk("wz_appear_vo",  32'(bus.valid_out), 32'h1);
        chk("wz_appear_out", 32'(bus.out), 32'h301);
        chk("wz_appear_cls", 32'(bus.out_class), 32'h3);

        // ---------------- backpressure / wrap ----------------
        do_reset("rst_bp");
        bus.weights = 12'h249;
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 300 && rcvd < 20; cyc++) begin
            bus.out_ready = cyc[0];
            if (sent < 20 && !bus.almost_full[1]) begin
                bus.valid_in = 1'b1;
                bus.in = 10'h100 + 10'(sent);
                sent++;
            end else begin
                bus.valid_in = 1'b0;
            end
            pv = bus.valid_out;
            pr = bus.out_ready;
            po = bus.out;
            pc = bus.out_class;
            step();
            if (pv && pr) begin
                chk($sformatf("bp_word%0d", rcvd), 32'(po), 32'h100 + 32'(rcvd));
                chk($sformatf("bp_cls%0d", rcvd),  32'(pc), 32'h1);
                rcvd++;
            end else if (pv) begin
                chk("bp_hold_vo",  32'(bus.valid_out), 32'h1);
                chk("bp_hold_out", 32'(bus.out), 32'(po));
                chk("bp_hold_cls", 32'(bus.out_class), 32'(pc));
            end
        end
        bus.valid_in = 1'b0;
        chk("bp_received", 32'(rcvd), 32'd20);
        bus.out_ready = 1'b1;
        step();
        chk("bp_end_vo", 32'(bus.valid_out), 32'h0);
        chk("bp_end_empty", 32'(bus.fifo_empty), 32'hF);

        // ---------------- reset mid-operation ----------------
        do_reset("rst_mid_pre");
        bus.weights = 12'h249;
        for (int k = 0; k < 6; k++) begin
            bus.valid_in = 1'b1;
            bus.in = 10'h010 + 10'(k);
            step();
        end
        bus.valid_in = 1'b0;
        chk("mid_pre_vo",    32'(bus.valid_out), 32'h1);
        chk("mid_pre_empty", 32'(bus.fifo_empty), 32'hE);
        #3 reset = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        step();
        step();
        #3 reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("mid_stale%0d_vo", k),    32'(bus.valid_out), 32'h0);
            chk($sformatf("mid_stale%0d_empty", k), 32'(bus.fifo_empty), 32'hF);
        end
        bus.valid_in = 1'b1;
        bus.in = 10'h3AA;
        step();
        bus.valid_in = 1'b0;
        chk("lat_e0_vo",    32'(bus.valid_out), 32'h0);
        chk("lat_e0_empty", 32'(bus.fifo_empty[3]), 32'h0);
        step();
        chk("lat_e1_vo",  32'(bus.valid_out), 32'h1);
        chk("lat_e1_out", 32'(bus.out), 32'h3AA);
        chk("lat_e1_cls", 32'(bus.out_class), 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
